// File: rtl/el2_bp_hash_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : el2_bp_hash_pipe
//  Purpose  : Speculative/retired GHR tracking plus folded BHT index and BTB
//             tag hashing behind a one-deep valid/ready output register.
//  Revision : 1.0  initial release
// ============================================================================
module el2_bp_hash_pipe #(
    parameter int ADDR_W    = 8,
    parameter int IDX_FOLDS = 2,
    parameter int INDEX_LO  = 1,
    parameter int GHR_W     = 8,
    parameter int TAG_W     = 5,
    parameter int TAG_FOLDS = 3
) (
    input  logic                         clk,
    input  logic                         rst_l,
    input  logic                         lookup_valid,
    output logic                         lookup_ready,
    input  logic [31:0]                  lookup_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ADDR_W-1:0]            out_index,
    output logic [TAG_W-1:0]             out_tag,
    input  logic                         pred_valid,
    input  logic                         pred_taken,
    input  logic                         ret_valid,
    input  logic                         ret_taken,
    input  logic                         flush,
    output logic [GHR_W-1:0]             ghr_spec,
    output logic [GHR_W-1:0]             ghr_ret,
    output logic [$clog2(GHR_W+1)-1:0]   inflight
);

    localparam int c_cnt_w   = $clog2(GHR_W + 1);
    localparam int c_gfolds  = (GHR_W + ADDR_W - 1) / ADDR_W;
    localparam int c_gpad_w  = c_gfolds * ADDR_W;
    localparam int c_tag_lo  = INDEX_LO + ADDR_W * IDX_FOLDS;
    localparam logic [c_cnt_w-1:0] c_inflight_max = c_cnt_w'(GHR_W);

    if ((ADDR_W < 2) || (IDX_FOLDS < 1) || (IDX_FOLDS > 4) ||
        (GHR_W < 2) || (GHR_W > ADDR_W * 4) ||
        (TAG_FOLDS < 1) || (TAG_FOLDS > 4) ||
        (c_tag_lo + TAG_W * TAG_FOLDS > 32)) begin : g_bad_cfg
        $error("el2_bp_hash_pipe: illegal parameter combination");
    end

    logic [GHR_W-1:0]    r_ghr_spec;
    logic [GHR_W-1:0]    r_ghr_ret;
    logic [c_cnt_w-1:0]  r_inflight;
    logic                r_out_valid;
    logic [ADDR_W-1:0]   r_out_index;
    logic [TAG_W-1:0]    r_out_tag;

    logic [GHR_W-1:0]    w_ghr_ret_nxt;
    logic                w_accept;
    logic [c_gpad_w-1:0] w_ghr_pad;
    logic [ADDR_W-1:0]   w_idx_chunk [IDX_FOLDS];
    logic [ADDR_W-1:0]   w_ghr_chunk [c_gfolds];
    logic [TAG_W-1:0]    w_tag_chunk [TAG_FOLDS];
    logic [ADDR_W-1:0]   w_index;
    logic [TAG_W-1:0]    w_tag;
    logic                w_unused_pc;

    // Only a slice of the PC feeds the hashes; the remainder is intentionally ignored.
    assign w_unused_pc = ^lookup_pc;

    assign w_ghr_pad = c_gpad_w'(r_ghr_spec);

    for (genvar g = 0; g < IDX_FOLDS; g++) begin : g_idx_chunk
        assign w_idx_chunk[g] = lookup_pc[INDEX_LO + g*ADDR_W +: ADDR_W];
    end

    for (genvar g = 0; g < c_gfolds; g++) begin : g_ghr_chunk
        assign w_ghr_chunk[g] = w_ghr_pad[g*ADDR_W +: ADDR_W];
    end

    for (genvar g = 0; g < TAG_FOLDS; g++) begin : g_tag_chunk
        assign w_tag_chunk[g] = lookup_pc[c_tag_lo + g*TAG_W +: TAG_W];
    end

    always_comb begin
        w_index = '0;
        w_tag   = '0;
        for (int k = 0; k < IDX_FOLDS; k++) w_index ^= w_idx_chunk[k];
        for (int k = 0; k < c_gfolds; k++)  w_index ^= w_ghr_chunk[k];
        for (int k = 0; k < TAG_FOLDS; k++) w_tag   ^= w_tag_chunk[k];
    end

    // A flush cycle refuses new lookups so no result is hashed against a stale history.
    assign lookup_ready  = (!r_out_valid || out_ready) && !flush;
    assign w_accept      = lookup_valid && lookup_ready;
    assign w_ghr_ret_nxt = ret_valid ? {r_ghr_ret[GHR_W-2:0], ret_taken} : r_ghr_ret;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_ghr_spec <= '0;
            r_ghr_ret  <= '0;
            r_inflight <= '0;
        end else begin
            r_ghr_ret <= w_ghr_ret_nxt;
            if (flush)
                r_ghr_spec <= w_ghr_ret_nxt;
            else if (pred_valid)
                r_ghr_spec <= {r_ghr_spec[GHR_W-2:0], pred_taken};

            if (flush)
                r_inflight <= '0;
            else if (pred_valid && !ret_valid && (r_inflight != c_inflight_max))
                r_inflight <= r_inflight + 1'b1;
            else if (ret_valid && !pred_valid && (r_inflight != '0))
                r_inflight <= r_inflight - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_out_valid <= 1'b0;
            r_out_index <= '0;
            r_out_tag   <= '0;
        end else begin
            if (flush)
                r_out_valid <= 1'b0;
            else if (w_accept)
                r_out_valid <= 1'b1;
            else if (out_ready)
                r_out_valid <= 1'b0;

            if (w_accept) begin
                r_out_index <= w_index;
                r_out_tag   <= w_tag;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_index = r_out_index;
    assign out_tag   = r_out_tag;
    assign ghr_spec  = r_ghr_spec;
    assign ghr_ret   = r_ghr_ret;
    assign inflight  = r_inflight;

endmodule
`default_nettype wire

// File: tb/tb_el2_bp_hash_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_el2_bp_hash_pipe
//  Purpose  : Directed self-checking bench for el2_bp_hash_pipe (default params).
//  Revision : 1.0  initial release
// ============================================================================
module tb_el2_bp_hash_pipe;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        lookup_valid, lookup_ready;
    logic [31:0] lookup_pc;
    logic        out_valid, out_ready;
    logic [7:0]  out_index;
    logic [4:0]  out_tag;
    logic        pred_valid, pred_taken, ret_valid, ret_taken, flush;
    logic [7:0]  ghr_spec, ghr_ret;
    logic [3:0]  inflight;

    int n_checks = 0;
    int n_errors = 0;

    el2_bp_hash_pipe dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .lookup_valid (lookup_valid),
        .lookup_ready (lookup_ready),
        .lookup_pc    (lookup_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_index    (out_index),
        .out_tag      (out_tag),
        .pred_valid   (pred_valid),
        .pred_taken   (pred_taken),
        .ret_valid    (ret_valid),
        .ret_taken    (ret_taken),
        .flush        (flush),
        .ghr_spec     (ghr_spec),
        .ghr_ret      (ghr_ret),
        .inflight     (inflight)
    );

    always #5 clk = ~clk;

    // Reference model: histories as integers, hashes as shift/mask arithmetic.
    int m_spec = 0, m_ret = 0, m_inf = 0, m_idx = 0, m_tag = 0;
    bit m_ov = 0;

    function automatic int f_index(input int pc, input int ghr);
        int upc;
        upc = pc;
        return (((upc >>> 1) & 255) ^ ((upc >>> 9) & 255) ^ (ghr & 255));
    endfunction

    function automatic int f_tag(input int pc);
        return (((pc >>> 17) ^ (pc >>> 22) ^ (pc >>> 27)) & 31);
    endfunction

    function automatic int f_ret_next();
        return ret_valid ? ((m_ret * 2 + int'(ret_taken)) % 256) : m_ret;
    endfunction

    function automatic bit f_ready();
        return (!m_ov || out_ready) && !flush;
    endfunction

    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            m_spec <= 0; m_ret <= 0; m_inf <= 0; m_idx <= 0; m_tag <= 0; m_ov <= 0;
        end else begin
            if (flush)
                m_ov <= 0;
            else if (lookup_valid && f_ready()) begin
                m_ov  <= 1;
                m_idx <= f_index(int'(lookup_pc), m_spec);
                m_tag <= f_tag(int'(lookup_pc));
            end else if (out_ready)
                m_ov <= 0;

            m_ret <= f_ret_next();
            if (flush)           m_spec <= f_ret_next();
            else if (pred_valid) m_spec <= (m_spec * 2 + int'(pred_taken)) % 256;

            if (flush)                       m_inf <= 0;
            else if (pred_valid && !ret_valid) m_inf <= (m_inf < 8) ? m_inf + 1 : 8;
            else if (ret_valid && !pred_valid) m_inf <= (m_inf > 0) ? m_inf - 1 : 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cmp.out_valid",    int'(out_valid),    int'(m_ov));
        chk("cmp.lookup_ready", int'(lookup_ready), int'(f_ready()));
        chk("cmp.out_index",    int'(out_index),    m_idx);
        chk("cmp.out_tag",      int'(out_tag),      m_tag);
        chk("cmp.ghr_spec",     int'(ghr_spec),     m_spec);
        chk("cmp.ghr_ret",      int'(ghr_ret),      m_ret);
        chk("cmp.inflight",     int'(inflight),     m_inf);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_lookup(input logic [31:0] pc);
        lookup_valid = 1'b1;
        lookup_pc    = pc;
        cyc(1);
        lookup_valid = 1'b0;
    endtask

    initial begin
        rst_l = 1'b0; lookup_valid = 1'b0; lookup_pc = '0; out_ready = 1'b1;
        pred_valid = 1'b0; pred_taken = 1'b0; ret_valid = 1'b0; ret_taken = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_l = 1'b1;
        chk("reset.out_valid", int'(out_valid), 0);
        chk("reset.ghr_spec",  int'(ghr_spec),  0);
        chk("reset.inflight",  int'(inflight),  0);
        cyc(1);

        do_lookup(32'h0000_0302);
        chk("lk302.out_valid", int'(out_valid), 1);
        chk("lk302.out_index", int'(out_index), 'h80);
        chk("lk302.out_tag",   int'(out_tag),   'h00);
        do_lookup(32'h0042_0000);
        chk("lk420000.out_index", int'(out_index), 'h00);
        chk("lk420000.out_tag",   int'(out_tag),   'h00);
        do_lookup(32'h0002_0000);
        chk("lk20000.out_tag", int'(out_tag), 'h01);

        pred_valid = 1'b1;
        pred_taken = 1'b1; cyc(1);
        pred_taken = 1'b1; cyc(1);
        pred_taken = 1'b0; cyc(1);
        pred_valid = 1'b0;
        chk("pred.ghr_spec", int'(ghr_spec), 'h06);
        chk("pred.inflight", int'(inflight), 3);
        do_lookup(32'h0000_0302);
        chk("pred.out_index", int'(out_index), 'h86);

        ret_valid = 1'b1; ret_taken = 1'b1; cyc(1);
        ret_taken = 1'b0; flush = 1'b1; lookup_valid = 1'b1; lookup_pc = 32'h0000_0302;
        #1 chk("flush.lookup_ready", int'(lookup_ready), 0);
        cyc(1);
        ret_valid = 1'b0; flush = 1'b0; lookup_valid = 1'b0;
        chk("flush.ghr_ret",   int'(ghr_ret),   'h02);
        chk("flush.ghr_spec",  int'(ghr_spec),  'h02);
        chk("flush.inflight",  int'(inflight),  0);
        chk("flush.out_valid", int'(out_valid), 0);
        cyc(1);

        out_ready = 1'b0;
        lookup_valid = 1'b1; lookup_pc = 32'h0042_0002;
        cyc(1);
        lookup_pc = 32'h0000_0302;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall.lookup_ready", int'(lookup_ready), 0);
            chk("stall.out_index",    int'(out_index),    'h03);
            chk("stall.out_valid",    int'(out_valid),    1);
            cyc(1);
        end
        out_ready = 1'b1;
        #1 chk("release.lookup_ready", int'(lookup_ready), 1);
        cyc(1);
        chk("release.out_index", int'(out_index), 'h82);
        chk("release.out_valid", int'(out_valid), 1);

        lookup_pc = 32'h0042_0000; cyc(1);
        chk("b2b.idx1", int'(out_index), 'h02);
        lookup_pc = 32'h0002_0000; cyc(1);
        chk("b2b.tag2", int'(out_tag), 'h01);
        chk("b2b.valid", int'(out_valid), 1);
        lookup_valid = 1'b0; cyc(1);

        pred_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pred_taken = i[0];
            cyc(1);
        end
        pred_valid = 1'b0;
        chk("sat.inflight", int'(inflight), 8);
        chk("sat.ghr_spec", int'(ghr_spec), 'h55);
        flush = 1'b1; cyc(1); flush = 1'b0;
        chk("sat.flush_inflight", int'(inflight), 0);
        ret_valid = 1'b1; ret_taken = 1'b1; cyc(1); ret_valid = 1'b0;
        chk("floor.inflight", int'(inflight), 0);
        chk("floor.ghr_ret",  int'(ghr_ret),  'h05);
        chk("floor.ghr_spec", int'(ghr_spec), 'h02);

        lookup_valid = 1'b1; lookup_pc = 32'h0000_0302;
        pred_valid = 1'b1; pred_taken = 1'b1;
        cyc(1);
        chk("pre_rst.out_index", int'(out_index), 'h82);
        #2 rst_l = 1'b0;
        #1;
        chk("arst.out_valid", int'(out_valid), 0);
        chk("arst.out_index", int'(out_index), 0);
        chk("arst.out_tag",   int'(out_tag),   0);
        chk("arst.ghr_spec",  int'(ghr_spec),  0);
        chk("arst.ghr_ret",   int'(ghr_ret),   0);
        chk("arst.inflight",  int'(inflight),  0);
        lookup_valid = 1'b0; pred_valid = 1'b0;
        @(posedge clk);
        #1 rst_l = 1'b1;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
